// File: rtl/fifo_pkg.sv
// Shared defaults and state encoding for the FIFO burst reader.
package fifo_pkg;
  localparam int FIFO_WIDTH_DEF = 16;
  localparam int LEN_W_DEF      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } reader_state_e;
endpackage

// File: rtl/fifo_reader_if.sv
// Burst control, FIFO read port and output stream of the FIFO reader.
interface fifo_reader_if import fifo_pkg::*; #(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int LEN_W      = LEN_W_DEF
) ();
  logic                  start;
  logic [LEN_W-1:0]      burst_len;
  logic                  fifo_empty;
  logic [FIFO_WIDTH-1:0] fifo_data_out;
  logic                  fifo_rd_en;
  logic                  m_valid;
  logic [FIFO_WIDTH-1:0] m_data;
  logic                  m_ready;
  logic                  busy;
  logic                  done;

  // master: the reader itself; slave: control, FIFO and downstream sink
  modport master (
    input  start, burst_len, fifo_empty, fifo_data_out, m_ready,
    output fifo_rd_en, m_valid, m_data, busy, done
  );
  modport slave (
    output start, burst_len, fifo_empty, fifo_data_out, m_ready,
    input  fifo_rd_en, m_valid, m_data, busy, done
  );
endinterface

// File: rtl/fifo_out_buf.sv
// Two-entry in-order output buffer with occupancy count.
module fifo_out_buf import fifo_pkg::*; #(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [FIFO_WIDTH-1:0] din,
  input  logic                  rd,
  output logic [FIFO_WIDTH-1:0] dout,
  output logic [1:0]            occ
);
  logic [FIFO_WIDTH-1:0] mem [2];
  logic                  wp, rp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (wr) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (rd) rp <= ~rp;
      occ <= occ + {1'b0, wr} - {1'b0, rd};
    end
  end

  assign dout = mem[rp];
endmodule

// File: rtl/fifo_reader.sv
// Reads a burst of words from a FIFO and streams them out with valid/ready,
// using read credits so the 2-entry output buffer can never overflow.
module fifo_reader import fifo_pkg::*; #(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int LEN_W      = LEN_W_DEF
) (
  input logic           clk,
  input logic           rst,
  fifo_reader_if.master bus
);
  reader_state_e         state, state_nxt;
  logic [LEN_W-1:0]      len, issued;
  logic                  inflight, done_q;
  logic [1:0]            occ;
  logic [FIFO_WIDTH-1:0] buf_dout;
  logic                  rd_en, pop, bypass, cap, buf_rd;
  logic [2:0]            credit;

  // With an empty buffer the in-flight word is presented straight from the
  // FIFO read port, giving the two-cycle first-word latency.
  assign bypass  = (occ == 2'd0) && inflight;
  assign pop     = bus.m_valid && bus.m_ready;
  assign cap     = inflight && !(bypass && pop);
  assign buf_rd  = pop && (occ != 2'd0);
  assign credit  = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};

  fifo_out_buf #(.FIFO_WIDTH(FIFO_WIDTH)) u_buf (
    .clk  (clk),
    .rst  (rst),
    .wr   (cap),
    .din  (bus.fifo_data_out),
    .rd   (buf_rd),
    .dout (buf_dout),
    .occ  (occ)
  );

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      IDLE:
        if (bus.start) state_nxt = (bus.burst_len != '0) ? READ : DONE;
      READ: begin
        rd_en = !bus.fifo_empty && (issued < len) && (credit < 3'd2);
        if (rd_en && (issued + LEN_W'(1) == len)) state_nxt = DRAIN;
      end
      DRAIN:
        if (credit == 3'd0) state_nxt = DONE;
      DONE:
        state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      len      <= '0;
      issued   <= '0;
      inflight <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= rd_en;
      // done is registered off the DONE state: a single clean pulse
      done_q   <= (state == DONE);
      if (state == IDLE && bus.start && bus.burst_len != '0) begin
        len    <= bus.burst_len;
        issued <= '0;
      end else if (rd_en) begin
        issued <= issued + LEN_W'(1);
      end
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = (occ != 2'd0) || inflight;
  assign bus.m_data     = (occ != 2'd0) ? buf_dout :
                          inflight      ? bus.fifo_data_out : '0;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_q;
endmodule

// File: tb/tb_fifo_reader.sv
// Randomized bench for fifo_reader: queue-based FIFO model plus an in-order
// scoreboard of every word ever written to the FIFO.
module tb_fifo_reader;
  import fifo_pkg::*;
  localparam int W  = FIFO_WIDTH_DEF;
  localparam int LW = LEN_W_DEF;

  logic clk = 1'b0;
  logic rst;
  fifo_reader_if #(.FIFO_WIDTH(W), .LEN_W(LW)) bus ();
  fifo_reader #(.FIFO_WIDTH(W), .LEN_W(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // FIFO model: read data appears the cycle after fifo_rd_en
  logic [W-1:0] fq[$];
  logic [W-1:0] hist[$];
  int popped = 0;
  always @(posedge clk)
    if (bus.fifo_rd_en && fq.size() > 0) begin
      bus.fifo_data_out <= fq.pop_front();
      popped <= popped + 1;
    end

  int cmp = 0, errs = 0, exp_idx = 0;
  int cyc, s_cyc, rd_cnt, done_cnt, done_cyc, first_vld, underflow, unstable;
  logic hold_pending, s_valid;
  logic [W-1:0] hold_data, s_data;
  logic [W-1:0] got_q[$];
  int got_cyc[$];

  task automatic clear_stats();
    cyc = 0; rd_cnt = 0; done_cnt = 0; done_cyc = -1; first_vld = -1;
    underflow = 0; unstable = 0; hold_pending = 1'b0;
    got_q.delete(); got_cyc.delete();
  endtask

  task automatic push(input logic [W-1:0] v);
    fq.push_back(v);
    hist.push_back(v);
    bus.fifo_empty = 1'b0;
  endtask

  // Sample one cycle at the falling edge, then advance to just past the rising edge.
  task automatic cycle();
    @(negedge clk);
    s_cyc = cyc; s_valid = bus.m_valid; s_data = bus.m_data;
    if (bus.fifo_rd_en) begin
      rd_cnt++;
      if (bus.fifo_empty) underflow++;
    end
    if (bus.done) begin done_cnt++; done_cyc = cyc; end
    if (bus.m_valid && first_vld < 0) first_vld = cyc;
    if (hold_pending && (!bus.m_valid || bus.m_data !== hold_data)) unstable++;
    hold_pending = bus.m_valid && !bus.m_ready;
    hold_data = bus.m_data;
    if (bus.m_valid && bus.m_ready) begin
      got_q.push_back(bus.m_data);
      got_cyc.push_back(cyc);
    end
    cyc++;
    @(posedge clk); #1;
    bus.fifo_empty = (fq.size() == 0);
  endtask

  task automatic begin_burst(input int len);
    clear_stats();
    bus.burst_len = LW'(len);
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
  endtask

  task automatic run(input int budget, input int pct);
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      bus.m_ready = (int'($urandom_range(99)) < pct);
      cycle();
    end
    repeat (2) cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.burst_len = '0;
    bus.fifo_empty = 1'b1; bus.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp++; if (bus.fifo_rd_en !== 1'b0) begin errs++; $display("FAIL reset_rd_en: got %b want 0", bus.fifo_rd_en); end
    cmp++; if (bus.m_valid !== 1'b0) begin errs++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
    cmp++; if (bus.m_data !== '0) begin errs++; $display("FAIL reset_m_data: got %h want 0", bus.m_data); end
    cmp++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    cmp++; if (bus.done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b want 0", bus.done); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    for (int v = 1; v <= 4; v++) push(W'(v));
    bus.m_ready = 1'b1;
    begin_burst(4);
    run(30, 100);
    cmp++; if (first_vld !== 2) begin errs++; $display("FAIL basic_latency: got %0d want 2", first_vld); end
    cmp++; if (got_q.size() !== 4) begin errs++; $display("FAIL basic_count: got %0d want 4", got_q.size()); end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      cmp++; if (got_q[k] !== W'(k + 1) || got_cyc[k] !== k + 2) begin
        errs++; $display("FAIL basic_word%0d: got %h@%0d want %h@%0d", k, got_q[k], got_cyc[k], k + 1, k + 2);
      end
    end
    cmp++; if (done_cnt !== 1) begin errs++; $display("FAIL basic_done: got %0d want 1", done_cnt); end
    cmp++; if (rd_cnt !== 4) begin errs++; $display("FAIL basic_rd: got %0d want 4", rd_cnt); end
    exp_idx += 4;
  endtask

  task automatic test_stall();
    for (int v = 1; v <= 3; v++) push(W'(v));
    bus.m_ready = 1'b0;
    begin_burst(3);
    for (int i = 1; i < 10; i++) begin
      cycle();
      if (s_cyc >= 2) begin
        cmp++; if (s_valid !== 1'b1 || s_data !== W'(1)) begin
          errs++; $display("FAIL stall_hold_c%0d: got v=%b d=%h want v=1 d=0001", s_cyc, s_valid, s_data);
        end
      end
    end
    cmp++; if (rd_cnt !== 2) begin errs++; $display("FAIL stall_rd: got %0d want 2", rd_cnt); end
    run(40, 100);
    cmp++; if (got_q.size() !== 3) begin errs++; $display("FAIL stall_count: got %0d want 3", got_q.size()); end
    for (int k = 0; k < 3 && k < got_q.size(); k++) begin
      cmp++; if (got_q[k] !== W'(k + 1)) begin errs++; $display("FAIL stall_word%0d: got %h want %h", k, got_q[k], k + 1); end
    end
    cmp++; if (done_cnt !== 1) begin errs++; $display("FAIL stall_done: got %0d want 1", done_cnt); end
    cmp++; if (rd_cnt !== 3) begin errs++; $display("FAIL stall_rd_total: got %0d want 3", rd_cnt); end
    cmp++; if (unstable !== 0) begin errs++; $display("FAIL stall_stable: got %0d want 0", unstable); end
    exp_idx += 3;
  endtask

  task automatic test_trickle();
    int n = 0;
    int base = exp_idx;
    bus.m_ready = 1'b1;
    begin_burst(4);
    for (int i = 0; i < 80 && done_cnt == 0; i++) begin
      if (i % 3 == 2 && n < 4) begin push(W'($urandom)); n++; end
      cycle();
    end
    repeat (2) cycle();
    cmp++; if (underflow !== 0) begin errs++; $display("FAIL trickle_underflow: got %0d want 0", underflow); end
    cmp++; if (rd_cnt !== 4) begin errs++; $display("FAIL trickle_rd: got %0d want 4", rd_cnt); end
    cmp++; if (got_q.size() !== 4) begin errs++; $display("FAIL trickle_count: got %0d want 4", got_q.size()); end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      cmp++; if (got_q[k] !== hist[base + k]) begin errs++; $display("FAIL trickle_word%0d: got %h want %h", k, got_q[k], hist[base + k]); end
    end
    cmp++; if (done_cnt !== 1) begin errs++; $display("FAIL trickle_done: got %0d want 1", done_cnt); end
    exp_idx += 4;
  endtask

  task automatic test_zero();
    begin_burst(0);
    repeat (5) cycle();
    cmp++; if (done_cyc !== 2) begin errs++; $display("FAIL zero_done_cycle: got %0d want 2", done_cyc); end
    cmp++; if (done_cnt !== 1) begin errs++; $display("FAIL zero_done_cnt: got %0d want 1", done_cnt); end
    cmp++; if (rd_cnt !== 0) begin errs++; $display("FAIL zero_rd: got %0d want 0", rd_cnt); end
    cmp++; if (first_vld !== -1) begin errs++; $display("FAIL zero_valid: got cycle %0d want none", first_vld); end
  endtask

  task automatic test_reset_mid();
    int base;
    for (int i = 0; i < 7; i++) push(W'($urandom));
    bus.m_ready = 1'b1;
    begin_burst(5);
    for (int i = 0; i < 20 && got_q.size() < 2; i++) cycle();
    rst = 1'b1;
    #1;
    cmp++; if (bus.fifo_rd_en !== 1'b0) begin errs++; $display("FAIL midrst_rd_en: got %b want 0", bus.fifo_rd_en); end
    cmp++; if (bus.m_valid !== 1'b0) begin errs++; $display("FAIL midrst_m_valid: got %b want 0", bus.m_valid); end
    cmp++; if (bus.m_data !== '0) begin errs++; $display("FAIL midrst_m_data: got %h want 0", bus.m_data); end
    cmp++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    cmp++; if (bus.done !== 1'b0) begin errs++; $display("FAIL midrst_done: got %b want 0", bus.done); end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_idx = popped;
    bus.fifo_empty = (fq.size() == 0);
    clear_stats();
    repeat (4) cycle();
    cmp++; if (done_cnt !== 0) begin errs++; $display("FAIL midrst_no_done: got %0d want 0", done_cnt); end
    cmp++; if (first_vld !== -1) begin errs++; $display("FAIL midrst_no_valid: got cycle %0d want none", first_vld); end
    base = exp_idx;
    begin_burst(2);
    run(30, 100);
    cmp++; if (got_q.size() !== 2) begin errs++; $display("FAIL midrst_count: got %0d want 2", got_q.size()); end
    for (int k = 0; k < 2 && k < got_q.size(); k++) begin
      cmp++; if (got_q[k] !== hist[base + k]) begin errs++; $display("FAIL midrst_word%0d: got %h want %h", k, got_q[k], hist[base + k]); end
    end
    cmp++; if (done_cnt !== 1) begin errs++; $display("FAIL midrst_done_cnt: got %0d want 1", done_cnt); end
    exp_idx += 2;
  endtask

  task automatic test_busy_start();
    int n = int'($urandom_range(3, 6));
    int base = exp_idx;
    for (int i = 0; i < n + 4; i++) push(W'($urandom));
    begin_burst(n);
    for (int i = 0; i < 200 && done_cnt == 0; i++) begin
      bus.m_ready = ($urandom_range(1) == 1);
      bus.start = (i == 2);
      bus.burst_len = LW'(n + 3);
      cycle();
    end
    bus.start = 1'b0;
    repeat (2) cycle();
    cmp++; if (done_cnt !== 1) begin errs++; $display("FAIL busy_done: got %0d want 1", done_cnt); end
    cmp++; if (rd_cnt !== n) begin errs++; $display("FAIL busy_rd: got %0d want %0d", rd_cnt, n); end
    cmp++; if (got_q.size() !== n) begin errs++; $display("FAIL busy_count: got %0d want %0d", got_q.size(), n); end
    for (int k = 0; k < n && k < got_q.size(); k++) begin
      cmp++; if (got_q[k] !== hist[base + k]) begin errs++; $display("FAIL busy_word%0d: got %h want %h", k, got_q[k], hist[base + k]); end
    end
    cmp++; if (unstable !== 0) begin errs++; $display("FAIL busy_stable: got %0d want 0", unstable); end
    exp_idx += n;
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int len = int'($urandom_range(1, 12));
      int pushes = 0;
      int base = exp_idx;
      begin_burst(len);
      for (int i = 0; i < 400 && done_cnt == 0; i++) begin
        if (pushes < len && $urandom_range(99) < 40) begin push(W'($urandom)); pushes++; end
        bus.m_ready = ($urandom_range(99) < 60);
        cycle();
      end
      repeat (2) cycle();
      cmp++; if (done_cnt !== 1) begin errs++; $display("FAIL rand%0d_done: got %0d want 1", it, done_cnt); end
      cmp++; if (rd_cnt !== len) begin errs++; $display("FAIL rand%0d_rd: got %0d want %0d", it, rd_cnt, len); end
      cmp++; if (got_q.size() !== len) begin errs++; $display("FAIL rand%0d_count: got %0d want %0d", it, got_q.size(), len); end
      for (int k = 0; k < len && k < got_q.size(); k++) begin
        cmp++; if (got_q[k] !== hist[base + k]) begin errs++; $display("FAIL rand%0d_word%0d: got %h want %h", it, k, got_q[k], hist[base + k]); end
      end
      cmp++; if (underflow !== 0 || unstable !== 0) begin
        errs++; $display("FAIL rand%0d_proto: got underflow=%0d unstable=%0d want 0/0", it, underflow, unstable);
      end
      exp_idx += len;
    end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_basic();
    test_stall();
    test_trickle();
    test_zero();
    test_reset_mid();
    test_busy_start();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
